// File: rtl/cla_nibble_seq.sv
// Multi-cycle add/subtract engine: one 4-bit CLA slice walked LSB nibble
// first, with the inter-nibble carry held in a register.
module cla_nibble_seq #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             SEL,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] Sum,
   output logic             Cout,
   output logic             ovf,
   output logic             zero
);

   localparam int NIB = WIDTH / 4;
   localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic             sel_q;
   logic             carry;
   logic [IW-1:0]    idx;

   logic [3:0]       a_n;
   logic [3:0]       b_n;
   logic [3:0]       bx;
   logic [3:0]       g;
   logic [3:0]       p;
   logic [4:0]       c;
   logic [3:0]       s;
   logic             last;

   always_comb begin
      a_n = '0;
      b_n = '0;
      for (int n = 0; n < NIB; n++) begin
         if (idx == IW'(n)) begin
            a_n = a_q[4*n +: 4];
            b_n = b_q[4*n +: 4];
         end
      end
   end

   // Subtract is A + ~B + 1; the +1 enters as the initial carry.
   assign bx = b_n ^ {4{sel_q}};
   assign g  = a_n & bx;
   assign p  = a_n ^ bx;

   always_comb begin
      c[0] = carry;
      for (int k = 0; k < 4; k++) begin
         c[k+1] = g[k] | (p[k] & c[k]);
      end
   end

   assign s    = p ^ c[3:0];
   assign last = (idx == IW'(NIB - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         a_q   <= '0;
         b_q   <= '0;
         sel_q <= 1'b0;
         carry <= 1'b0;
         idx   <= '0;
         Sum   <= '0;
         Cout  <= 1'b0;
         ovf   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  a_q   <= a;
                  b_q   <= b;
                  sel_q <= SEL;
                  carry <= SEL;
                  idx   <= '0;
                  Sum   <= '0;
                  state <= RUN;
               end
            end
            RUN: begin
               for (int n = 0; n < NIB; n++) begin
                  if (idx == IW'(n)) Sum[4*n +: 4] <= s;
               end
               carry <= c[4];
               idx   <= idx + IW'(1);
               if (last) begin
                  Cout  <= c[4];
                  ovf   <= c[3] ^ c[4];
                  state <= DONE;
               end
            end
            DONE: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   assign busy = (state == RUN);
   assign done = (state == DONE);
   assign zero = (Sum == '0);

endmodule

// File: tb/tb_cla_nibble_seq.sv
// Self-checking bench for cla_nibble_seq: vector table through a
// scoreboard queue, plus protocol, back-to-back and reset sequences.
module tb_cla_nibble_seq;

   localparam int W   = 16;
   localparam int NIB = W / 4;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         sel;
      logic [W-1:0] sum;
      logic         cout;
      logic         ovf;
      logic         zero;
   } vec_t;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         SEL = 1'b0;
   logic         busy;
   logic         done;
   logic [W-1:0] Sum;
   logic         Cout;
   logic         ovf;
   logic         zero;

   int   n_chk = 0;
   int   n_fail = 0;
   vec_t sb[$];

   cla_nibble_seq #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .a     (a),
      .b     (b),
      .SEL   (SEL),
      .busy  (busy),
      .done  (done),
      .Sum   (Sum),
      .Cout  (Cout),
      .ovf   (ovf),
      .zero  (zero)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic vec_t model(input logic [W-1:0] va,
                                  input logic [W-1:0] vb,
                                  input logic vs);
      vec_t         v;
      logic [W-1:0] bx;
      logic [W:0]   r;
      bx = vs ? ~vb : vb;
      r  = {1'b0, va} + {1'b0, bx} + (W+1)'(vs);
      v.a    = va;
      v.b    = vb;
      v.sel  = vs;
      v.sum  = r[W-1:0];
      v.cout = r[W];
      v.ovf  = (va[W-1] == bx[W-1]) && (r[W-1] != va[W-1]);
      v.zero = (r[W-1:0] == '0);
      return v;
   endfunction

   task automatic do_op(input vec_t v);
      vec_t e;
      int   n;
      int   bcnt;
      @(negedge clk);
      a     = v.a;
      b     = v.b;
      SEL   = v.sel;
      start = 1'b1;
      sb.push_back(v);
      @(negedge clk);
      start = 1'b0;
      n    = 0;
      bcnt = 0;
      while (!done && n < 20) begin
         if (busy) bcnt++;
         @(negedge clk);
         n++;
      end
      chk("latency", n, NIB);
      chk("busy_cycles", bcnt, NIB);
      if (sb.size() > 0) begin
         e = sb.pop_front();
         chk("sum", Sum, e.sum);
         chk("cout", Cout, e.cout);
         chk("ovf", ovf, e.ovf);
         chk("zero", zero, e.zero);
      end else begin
         chk("scoreboard_empty", 1, 0);
      end
      @(negedge clk);
      chk("done_one_cycle", done, 0);
      chk("sum_held", Sum, e.sum);
   endtask

   initial begin
      vec_t tbl[8];
      vec_t v;
      int   dn;
      int   t;
      int   dpos[$];
      logic [W-1:0] got;

      tbl[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0};
      tbl[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
      tbl[2] = '{16'h0005, 16'h0003, 1'b1, 16'h0002, 1'b1, 1'b0, 1'b0};
      tbl[3] = '{16'h0003, 16'h000B, 1'b1, 16'hFFF8, 1'b0, 1'b0, 1'b0};
      tbl[4] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0};
      tbl[5] = '{16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0};
      tbl[6] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1};
      tbl[7] = '{16'h1234, 16'h4321, 1'b1, 16'hCF13, 1'b0, 1'b0, 1'b0};

      @(negedge clk);
      @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_sum", Sum, 0);
      chk("rst_cout", Cout, 0);
      chk("rst_ovf", ovf, 0);
      chk("rst_zero", zero, 1);
      rst_n = 1'b1;

      for (int i = 0; i < 8; i++) do_op(tbl[i]);

      for (int i = 0; i < 6; i++) begin
         v = model(W'($urandom), W'($urandom), 1'($urandom));
         do_op(v);
      end

      // start during busy must be ignored, operands changes too
      @(negedge clk);
      a = 16'h1111; b = 16'h2222; SEL = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      a = 16'hFFFF; b = 16'h0001; SEL = 1'b1; start = 1'b1;
      @(negedge clk);
      start = 1'b0; a = '0; b = '0;
      dn  = 0;
      got = '0;
      for (int k = 0; k < 12; k++) begin
         if (done) begin
            dn++;
            got = Sum;
         end
         @(negedge clk);
      end
      chk("ignored_start_dones", dn, 1);
      chk("ignored_start_sum", got, 16'h3333);

      // start held high: one op every NIB+2 cycles
      v = model(16'h0F0F, 16'h00F1, 1'b0);
      a = v.a; b = v.b; SEL = v.sel; start = 1'b1;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (done) begin
            dpos.push_back(k);
            chk("b2b_sum", Sum, v.sum);
         end
      end
      start = 1'b0;
      chk("b2b_pulse_count_ok", dpos.size() >= 5, 1);
      for (int k = 1; k < dpos.size(); k++) begin
         chk("b2b_interval", dpos[k] - dpos[k-1], NIB + 2);
      end
      t = 0;
      while ((busy || done) && t < 20) begin
         @(negedge clk);
         t++;
      end
      chk("b2b_drain", busy | done, 0);

      // async reset two cycles into an operation
      @(negedge clk);
      a = 16'h1234; b = 16'h4321; SEL = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("pre_rst_busy", busy, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_done", done, 0);
      chk("mid_rst_sum", Sum, 0);
      chk("mid_rst_zero", zero, 1);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      dn = 0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (done || busy) dn++;
      end
      chk("post_rst_quiet", dn, 0);
      do_op(model(16'hABCD, 16'h1234, 1'b1));

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

endmodule
